pe_mul_sched: RTL and testbench

- Job-level sequencer for the 16-lane pe_mul multiplier array.
- Accepts a job descriptor (beat count, data type) and pulls operand pairs from the feature stream (lm, 64 b) and the weight stream (rm, 16x64 b) with a joint valid/ready handshake.
- Drives pe_mul operand registers and tracks pe_mul pipeline latency with a valid/last shift chain.
- Buffers the 320-bit products in an output FIFO so downstream backpressure never loses an in-flight product.

---
 rtl/pe_pkg.sv | 28 ++
 rtl/pe_mul_ofifo.sv | 64 ++++++
 rtl/pe_mul_sched.sv | 206 ++++++++++++++++++++
 tb/tb_pe_mul_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the pe_mul job sequencer and its output FIFO.
//   - Lane/width constants of the 16-lane pe_mul array
//   - Data_type encodings (2'b11 is reserved and rejected at job start)
//   - Sequencer FSM state type
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_LANES   = 16;
  localparam int LM_W       = 64;
  localparam int RM_W       = PE_LANES * LM_W;
  localparam int OUT_LANE_W = 20;
  localparam int MUL_OUT_W  = PE_LANES * OUT_LANE_W;

  localparam logic [1:0] DTYPE_INT8  = 2'b00;
  localparam logic [1:0] DTYPE_INT16 = 2'b01;
  localparam logic [1:0] DTYPE_FP16  = 2'b10;
  localparam logic [1:0] DTYPE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pe_mul_ofifo.sv
// -----------------------------------------------------------------------------
// pe_mul_ofifo
// Synchronous first-word-fall-through FIFO holding pe_mul products.
// The head entry is always visible on rd_dat while the FIFO is not empty.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wr_en, wr_dat   push (accepted when not full, or when full with a pop)
//   rd_en           pop of the head entry (ignored when empty)
//   rd_dat          head entry
//   full, empty     occupancy flags
//   count           number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module pe_mul_ofifo #(
  parameter int WIDTH = 321,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pe_mul_sched.sv
// -----------------------------------------------------------------------------
// pe_mul_sched
// Job-level sequencer for the 16-lane pe_mul multiplier array. A job of
// cfg_len operand beats is pulled from the feature (lm) and weight (rm)
// streams with a joint handshake, registered into pe_mul, tracked through the
// pe_mul latency with a valid/last chain, and buffered in an output FIFO.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   start, cfg_len, cfg_dtype  job request (sampled only in IDLE)
//   busy, done, err            status: not idle / completion pulse / reserved dtype pulse
//   lm_in/valid/ready          feature operand stream (64 b)
//   rm_in/valid/ready          weight operand stream (16 x 64 b)
//   mul_lm, mul_rm, mul_dtype  registered operands to pe_mul
//   mul_dat                    pe_mul product (16 x 20 b)
//   out_dat/valid/ready/last   product stream with end-of-job marker
// -----------------------------------------------------------------------------
module pe_mul_sched
  import pe_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int OFIFO_DEPTH = 4,
  parameter int LEN_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [1:0]            cfg_dtype,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [LM_W-1:0]       lm_in,
  input  logic                  lm_valid,
  output logic                  lm_ready,
  input  logic [RM_W-1:0]       rm_in,
  input  logic                  rm_valid,
  output logic                  rm_ready,
  output logic [LM_W-1:0]       mul_lm,
  output logic [RM_W-1:0]       mul_rm,
  output logic [1:0]            mul_dtype,
  input  logic [MUL_OUT_W-1:0]  mul_dat,
  output logic [MUL_OUT_W-1:0]  out_dat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int CW = $clog2(OFIFO_DEPTH) + 1;

  state_t               state;
  state_t               state_nx;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     issue_cnt;
  logic [CW-1:0]        credit;
  logic                 has_credit;
  logic                 run_ready;
  logic                 issue;
  logic                 issue_last;
  logic                 pop;
  logic                 start_ok;
  logic                 start_rsvd;
  logic [MUL_LAT-1:0]   vld_chain;
  logic [MUL_LAT-1:0]   last_chain;
  logic                 chain_empty;
  logic                 fifo_wr;
  logic [MUL_OUT_W:0]   fifo_rd_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  assign start_ok    = start & (cfg_dtype != DTYPE_RSVD);
  assign start_rsvd  = start & (cfg_dtype == DTYPE_RSVD);

  // Credit counts products issued but not yet popped, so the FIFO always has room
  // for everything in the pe_mul pipeline.
  assign has_credit  = (credit < CW'(OFIFO_DEPTH));
  assign issue       = run_ready & lm_valid & rm_valid;
  assign issue_last  = issue & (issue_cnt == (len_r - LEN_W'(1)));
  assign pop         = out_valid & out_ready;
  assign chain_empty = (vld_chain == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; DRAIN also exits in the cycle the final product is popped
  // so done follows the last accepted beat by one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nx = (cfg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_last) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (chain_empty && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    run_ready = (state == ST_RUN) & has_credit;
  end

  assign lm_ready = run_ready;
  assign rm_ready = run_ready;

  // Job configuration, issue counter and operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r     <= '0;
      issue_cnt <= '0;
      mul_dtype <= '0;
      mul_lm    <= '0;
      mul_rm    <= '0;
      err       <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) & start_rsvd;
      if (state == ST_IDLE && start_ok && cfg_len != '0) begin
        len_r     <= cfg_len;
        mul_dtype <= cfg_dtype;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + LEN_W'(1);
      end
      if (issue) begin
        mul_lm <= lm_in;
        mul_rm <= rm_in;
      end
    end
  end

  // Outstanding-product credit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
    end else begin
      if (issue && !pop) begin
        credit <= credit + CW'(1);
      end else if (!issue && pop) begin
        credit <= credit - CW'(1);
      end
    end
  end

  // Valid/last chain mirroring the pe_mul pipeline depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_chain  <= '0;
      last_chain <= '0;
    end else begin
      vld_chain[0]  <= issue;
      last_chain[0] <= issue_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_chain[i]  <= vld_chain[i-1];
        last_chain[i] <= last_chain[i-1];
      end
    end
  end

  assign fifo_wr = vld_chain[MUL_LAT-1];

  pe_mul_ofifo #(
    .WIDTH (MUL_OUT_W + 1),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fifo_wr),
    .wr_dat ({last_chain[MUL_LAT-1], mul_dat}),
    .rd_en  (pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_dat   = fifo_rd_dat[MUL_OUT_W-1:0];
  assign out_last  = fifo_rd_dat[MUL_OUT_W];

  // The credit scheme must make an overflowing write impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_wr && fifo_full && !pop));

endmodule

// File: tb/tb_pe_mul_sched.sv
// -----------------------------------------------------------------------------
// tb_pe_mul_sched
// Self-checking bench for pe_mul_sched. A stand-in pe_mul produces a lane-wise
// function of the registered operands; a job-level reference model predicts
// readies, product beats, status pulses and operand registers every cycle.
// -----------------------------------------------------------------------------
module tb_pe_mul_sched;

  localparam int MUL_LAT     = 2;
  localparam int OFIFO_DEPTH = 4;
  localparam int LEN_W       = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [1:0]        cfg_dtype;
  logic              busy;
  logic              done;
  logic              err;
  logic [63:0]       lm_in;
  logic              lm_valid;
  logic              lm_ready;
  logic [1023:0]     rm_in;
  logic              rm_valid;
  logic              rm_ready;
  logic [63:0]       mul_lm;
  logic [1023:0]     mul_rm;
  logic [1:0]        mul_dtype;
  logic [319:0]      mul_dat;
  logic [319:0]      out_dat;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  always #5 clk = ~clk;

  pe_mul_sched #(
    .MUL_LAT     (MUL_LAT),
    .OFIFO_DEPTH (OFIFO_DEPTH),
    .LEN_W       (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_dtype (cfg_dtype),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lm_in     (lm_in),
    .lm_valid  (lm_valid),
    .lm_ready  (lm_ready),
    .rm_in     (rm_in),
    .rm_valid  (rm_valid),
    .rm_ready  (rm_ready),
    .mul_lm    (mul_lm),
    .mul_rm    (mul_rm),
    .mul_dtype (mul_dtype),
    .mul_dat   (mul_dat),
    .out_dat   (out_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Lane i result: feature low bits plus weight lane low bits plus lane index.
  function automatic logic [319:0] ref_prod(input logic [63:0] lm, input logic [1023:0] rm);
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[i*20 +: 20] = lm[19:0] + rm[i*64 +: 20] + 20'(i);
    end
    return r;
  endfunction

  // Stand-in pe_mul: product valid MUL_LAT-1 register stages after the operands.
  logic [319:0] pm_pipe [MUL_LAT-1];
  always @(posedge clk) begin
    pm_pipe[0] <= ref_prod(mul_lm, mul_rm);
    for (int i = 1; i < MUL_LAT-1; i++) begin
      pm_pipe[i] <= pm_pipe[i-1];
    end
  end
  assign mul_dat = pm_pipe[MUL_LAT-2];

  typedef struct {
    int           rdy;
    logic [319:0] dat;
    logic         last;
  } beat_t;

  beat_t         pend[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            active;
  int            job_len;
  int            issued;
  int            popped;
  int            done_cyc;
  int            err_cyc;
  logic [1:0]    exp_dtype;
  logic [63:0]   exp_lm;
  logic [1023:0] exp_rm;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    active    = 1'b0;
    job_len   = 0;
    issued    = 0;
    popped    = 0;
    done_cyc  = -1;
    err_cyc   = -1;
    exp_dtype = '0;
    exp_lm    = '0;
    exp_rm    = '0;
  endtask

  task automatic rand_ops();
    lm_in = {$urandom, $urandom};
    for (int i = 0; i < 32; i++) begin
      rm_in[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      320'(busy), '0);
    check({tag, "_done"},      320'(done), '0);
    check({tag, "_err"},       320'(err), '0);
    check({tag, "_lm_ready"},  320'(lm_ready), '0);
    check({tag, "_rm_ready"},  320'(rm_ready), '0);
    check({tag, "_out_valid"}, 320'(out_valid), '0);
    check({tag, "_out_last"},  320'(out_last), '0);
    check({tag, "_out_dat"},   out_dat, '0);
    check({tag, "_mul_lm"},    320'(mul_lm), '0);
    check({tag, "_mul_dtype"}, 320'(mul_dtype), '0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_mul_rm[%0d]", tag, i), 320'(mul_rm[i*64 +: 64]), '0);
    end
  endtask

  // One clock cycle: compare every output against the model mid-cycle, then
  // advance the model with this cycle's handshakes and move past the next edge.
  task automatic cycle_check();
    bit exp_rdy;
    bit exp_ov;
    @(negedge clk);
    exp_rdy = active && (issued < job_len) && ((issued - popped) < OFIFO_DEPTH);
    exp_ov  = (pend.size() > 0) && (pend[0].rdy <= cyc);
    check("busy",      320'(busy), 320'(active));
    check("done",      320'(done), 320'(cyc == done_cyc));
    check("err",       320'(err), 320'(cyc == err_cyc));
    check("lm_ready",  320'(lm_ready), 320'(exp_rdy));
    check("rm_ready",  320'(rm_ready), 320'(exp_rdy));
    check("out_valid", 320'(out_valid), 320'(exp_ov));
    check("mul_lm",    320'(mul_lm), 320'(exp_lm));
    check("mul_dtype", 320'(mul_dtype), 320'(exp_dtype));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("mul_rm[%0d]", i), 320'(mul_rm[i*64 +: 64]), 320'(exp_rm[i*64 +: 64]));
    end
    if (exp_ov) begin
      check("out_dat",  out_dat, pend[0].dat);
      check("out_last", 320'(out_last), 320'(pend[0].last));
    end
    if (start && !active) begin
      if (cfg_dtype == 2'b11) begin
        err_cyc = cyc + 1;
      end else if (cfg_len == '0) begin
        active   = 1'b1;
        job_len  = 0;
        done_cyc = cyc + 1;
      end else begin
        active    = 1'b1;
        job_len   = int'(cfg_len);
        issued    = 0;
        popped    = 0;
        exp_dtype = cfg_dtype;
      end
    end
    if (exp_rdy && lm_valid && rm_valid) begin
      pend.push_back('{cyc + MUL_LAT + 1, ref_prod(lm_in, rm_in), (issued == job_len - 1)});
      exp_lm = lm_in;
      exp_rm = rm_in;
      issued++;
    end
    if (exp_ov && out_ready) begin
      if (pend[0].last) begin
        done_cyc = cyc + 1;
      end
      void'(pend.pop_front());
      popped++;
    end
    if (cyc == done_cyc) begin
      active = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_job(input int len, input logic [1:0] dtype);
    start     = 1'b1;
    cfg_len   = LEN_W'(len);
    cfg_dtype = dtype;
    rand_ops();
    cycle_check();
    start = 1'b0;
  endtask

  initial begin
    int n;
    start     = 1'b0;
    cfg_len   = '0;
    cfg_dtype = '0;
    lm_in     = '0;
    rm_in     = '0;
    lm_valid  = 1'b0;
    rm_valid  = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset released");

    // Basic job: len=3, always valid, always ready
    lm_valid  = 1'b1;
    rm_valid  = 1'b1;
    out_ready = 1'b1;
    start_job(3, 2'd0);
    n = 0;
    while (active && n < 40) begin
      rand_ops();
      cycle_check();
      n++;
    end
    check("basic_end_busy", 320'(busy), '0);

    // Backpressure: len=8, output stalled then released
    out_ready = 1'b0;
    start_job(8, 2'd1);
    repeat (10) begin
      rand_ops();
      cycle_check();
    end
    out_ready = 1'b1;
    n = 0;
    while (active && n < 80) begin
      rand_ops();
      cycle_check();
      n++;
    end
    check("bp_end_busy", 320'(busy), '0);

    // Reserved dtype
    start_job(5, 2'd3);
    repeat (3) cycle_check();

    // Zero length
    start_job(0, 2'd2);
    repeat (3) cycle_check();

    // Stalled weight operand: rm_valid 1,0,1 while lm_valid=1
    start_job(3, 2'd2);
    rm_valid = 1'b1; rand_ops(); cycle_check();
    rm_valid = 1'b0; rand_ops(); cycle_check();
    rm_valid = 1'b1; rand_ops(); cycle_check();
    n = 0;
    while (active && n < 40) begin
      rand_ops();
      cycle_check();
      n++;
    end
    check("stall_end_busy", 320'(busy), '0);

    // Randomized jobs with random valids, backpressure and spurious starts
    for (int j = 0; j < 4; j++) begin
      lm_valid  = 1'b1;
      rm_valid  = 1'b1;
      out_ready = 1'b1;
      start_job(int'($urandom_range(20, 5)), 2'($urandom_range(2, 0)));
      n = 0;
      while (active && n < 400) begin
        rand_ops();
        lm_valid  = ($urandom_range(3, 0) != 0);
        rm_valid  = ($urandom_range(3, 0) != 0);
        out_ready = ($urandom_range(2, 0) != 0);
        start     = ($urandom_range(3, 0) == 0);
        cfg_len   = LEN_W'($urandom_range(9, 0));
        cfg_dtype = 2'($urandom_range(3, 0));
        cycle_check();
        n++;
      end
      start = 1'b0;
      check($sformatf("rand%0d_end_busy", j), 320'(busy), '0);
    end

    // Asynchronous reset while draining
    lm_valid  = 1'b1;
    rm_valid  = 1'b1;
    out_ready = 1'b0;
    start_job(4, 2'd1);
    repeat (7) begin
      rand_ops();
      cycle_check();
    end
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) cycle_check();
    start_job(2, 2'd0);
    n = 0;
    while (active && n < 40) begin
      rand_ops();
      cycle_check();
      n++;
    end
    check("post_rst_end_busy", 320'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
